// File: rtl/regfile_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback_queue
// Brief    : Two-producer (ALU priority, mul/div) writeback FIFO feeding the
//            register-file write port, with two forwarding lookup ports.
//            Optional macro WB_QUEUE_STATS_EN adds a producer stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_writeback_queue #(
    parameter  int BIT_WIDTH = 32,
    parameter  int REG_COUNT = 32,
    parameter  int DEPTH     = 4,
    localparam int AW        = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 aluValid,
    input  logic [AW-1:0]        aluAddr,
    input  logic [BIT_WIDTH-1:0] aluData,
    output logic                 aluReady,
    input  logic                 mduValid,
    input  logic [AW-1:0]        mduAddr,
    input  logic [BIT_WIDTH-1:0] mduData,
    output logic                 mduReady,
    output logic                 write,
    output logic [AW-1:0]        wAddr,
    output logic [BIT_WIDTH-1:0] wData,
    input  logic [AW-1:0]        qAddr1,
    input  logic [AW-1:0]        qAddr2,
    output logic                 qHit1,
    output logic                 qHit2,
    output logic [BIT_WIDTH-1:0] qData1,
    output logic [BIT_WIDTH-1:0] qData2,
    output logic [CW-1:0]        count
`ifdef WB_QUEUE_STATS_EN
    ,
    output logic [31:0]          stallCycles
`endif
);

    localparam int            PW      = CW - 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [AW-1:0]        r_addr [DEPTH];
    logic [BIT_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]     r_vld;
    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic [CW-1:0]        r_count;

    logic                 w_drain;
    logic                 w_space;
    logic                 w_alu_acc;
    logic                 w_mdu_acc;
    logic                 w_push;
    logic [AW-1:0]        w_push_addr;
    logic [BIT_WIDTH-1:0] w_push_data;

    // A synchronous reset drops the head instead of committing it.
    assign w_drain     = enable && !reset && (r_count != '0);
    assign w_space     = (r_count < C_DEPTH) || w_drain;
    assign aluReady    = enable && w_space;
    assign mduReady    = enable && w_space && !aluValid;
    assign w_alu_acc   = aluValid && aluReady;
    assign w_mdu_acc   = mduValid && mduReady;
    assign w_push_addr = w_alu_acc ? aluAddr : mduAddr;
    assign w_push_data = w_alu_acc ? aluData : mduData;
    assign w_push      = (w_alu_acc || w_mdu_acc) && (w_push_addr != '0);

    assign write = w_drain;
    assign wAddr = w_drain ? r_addr[r_head] : '0;
    assign wData = w_drain ? r_data[r_head] : '0;
    assign count = r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else if (enable) begin
            if (w_drain) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            // Push after pop so a full-queue push into the freed slot wins.
            if (w_push) begin
                r_addr[r_tail] <= w_push_addr;
                r_data[r_tail] <= w_push_data;
                r_vld[r_tail]  <= 1'b1;
                r_tail         <= r_tail + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_drain);
        end
    end

    // Scan oldest to youngest so the last match is the youngest entry.
    always_comb begin : fwd
        logic [PW-1:0] v_idx;
        v_idx  = '0;
        qHit1  = 1'b0;
        qHit2  = 1'b0;
        qData1 = '0;
        qData2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_idx = r_head + PW'(i);
            if (r_vld[v_idx] && (qAddr1 != '0) && (r_addr[v_idx] == qAddr1)) begin
                qHit1  = 1'b1;
                qData1 = r_data[v_idx];
            end
            if (r_vld[v_idx] && (qAddr2 != '0) && (r_addr[v_idx] == qAddr2)) begin
                qHit2  = 1'b1;
                qData2 = r_data[v_idx];
            end
        end
    end

`ifdef WB_QUEUE_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stallCycles <= '0;
        end else if (enable && ((aluValid && !aluReady) || (mduValid && !mduReady))) begin
            stallCycles <= stallCycles + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_writeback_queue
// Brief    : Vector table plus queue scoreboard for regfile_writeback_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback_queue;

    logic        clock = 1'b0;
    logic        reset, enable;
    logic        aluValid, mduValid, aluReady, mduReady;
    logic [4:0]  aluAddr, mduAddr, wAddr, qAddr1, qAddr2;
    logic [31:0] aluData, mduData, wData, qData1, qData2;
    logic        write, qHit1, qHit2;
    logic [2:0]  count;
`ifdef WB_QUEUE_STATS_EN
    logic [31:0] stallCycles;
`endif

    regfile_writeback_queue dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .aluValid (aluValid),
        .aluAddr  (aluAddr),
        .aluData  (aluData),
        .aluReady (aluReady),
        .mduValid (mduValid),
        .mduAddr  (mduAddr),
        .mduData  (mduData),
        .mduReady (mduReady),
        .write    (write),
        .wAddr    (wAddr),
        .wData    (wData),
        .qAddr1   (qAddr1),
        .qAddr2   (qAddr2),
        .qHit1    (qHit1),
        .qHit2    (qHit2),
        .qData1   (qData1),
        .qData2   (qData2),
`ifdef WB_QUEUE_STATS_EN
        .stallCycles (stallCycles),
`endif
        .count    (count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        bit          en;
        bit          av;
        logic [4:0]  aa;
        logic [31:0] ad;
        bit          mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic [4:0]  q1;
        logic [4:0]  q2;
        int          exp_count;
        bit          exp_write;
    } vec_t;

    ent_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check mid-cycle, advance the model.
    // exp_cnt < 0 means no table expectation for count/write.
    task automatic step(input bit rst_i, input bit en_i,
                        input bit av_i, input logic [4:0] aa_i, input logic [31:0] ad_i,
                        input bit mv_i, input logic [4:0] ma_i, input logic [31:0] md_i,
                        input logic [4:0] q1_i, input logic [4:0] q2_i,
                        input int exp_cnt, input bit exp_wr);
        bit          drain, space, er_a, er_m, h1, h2;
        logic [31:0] d1, d2;
        @(negedge clock);
        reset = rst_i; enable = en_i;
        aluValid = av_i; aluAddr = aa_i; aluData = ad_i;
        mduValid = mv_i; mduAddr = ma_i; mduData = md_i;
        qAddr1 = q1_i; qAddr2 = q2_i;
        #1;
        drain = en_i && !rst_i && (sb.size() > 0);
        space = (sb.size() < 4) || drain;
        er_a  = en_i && space;
        er_m  = er_a && !av_i;
        if (!rst_i) begin
            h1 = 0; h2 = 0; d1 = 0; d2 = 0;
            foreach (sb[i]) begin
                if (q1_i != 0 && sb[i].a == q1_i) begin h1 = 1; d1 = sb[i].d; end
                if (q2_i != 0 && sb[i].a == q2_i) begin h2 = 1; d2 = sb[i].d; end
            end
            chk("aluReady", {31'b0, aluReady}, {31'b0, er_a});
            chk("mduReady", {31'b0, mduReady}, {31'b0, er_m});
            chk("write", {31'b0, write}, {31'b0, drain});
            chk("count", {29'b0, count}, sb.size());
            chk("wAddr", {27'b0, wAddr}, drain ? {27'b0, sb[0].a} : 32'd0);
            chk("wData", wData, drain ? sb[0].d : 32'd0);
            chk("qHit1", {31'b0, qHit1}, {31'b0, h1});
            chk("qData1", qData1, d1);
            chk("qHit2", {31'b0, qHit2}, {31'b0, h2});
            chk("qData2", qData2, d2);
            if (exp_cnt >= 0) begin
                chk("tbl_count", {29'b0, count}, exp_cnt);
                chk("tbl_write", {31'b0, write}, {31'b0, exp_wr});
            end
`ifdef WB_QUEUE_STATS_EN
            chk("stallCycles", stallCycles, exp_stall);
`endif
        end
        if (rst_i) begin
            sb.delete();
            exp_stall = 0;
        end else begin
            if (en_i && ((av_i && !er_a) || (mv_i && !er_m))) exp_stall++;
            if (drain) void'(sb.pop_front());
            if (av_i && er_a) begin
                if (aa_i != 0) sb.push_back('{aa_i, ad_i});
            end else if (mv_i && er_m && ma_i != 0) begin
                sb.push_back('{ma_i, md_i});
            end
        end
    endtask

    vec_t tbl[16];

    initial begin
        reset = 1; enable = 0;
        aluValid = 0; aluAddr = 0; aluData = 0;
        mduValid = 0; mduAddr = 0; mduData = 0;
        qAddr1 = 0; qAddr2 = 0;

        //         en av aa  ad            mv ma md     q1 q2 cnt wr
        tbl[0]  = '{1, 1, 5, 32'hDEADBEEF, 0, 0, 0,     5, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0,            0, 0, 0,     5, 0, 1, 1};
        tbl[2]  = '{1, 0, 0, 0,            0, 0, 0,     5, 0, 0, 0};
        tbl[3]  = '{1, 1, 3, 32'hA1,       1, 4, 32'hB4, 3, 4, 0, 0};
        tbl[4]  = '{1, 1, 3, 32'hA2,       1, 4, 32'hB4, 3, 4, 1, 1};
        tbl[5]  = '{1, 1, 3, 32'hA3,       1, 4, 32'hB4, 3, 4, 1, 1};
        tbl[6]  = '{1, 0, 0, 0,            1, 4, 32'hB4, 3, 4, 1, 1};
        tbl[7]  = '{1, 0, 0, 0,            0, 0, 0,     3, 4, 1, 1};
        tbl[8]  = '{1, 0, 0, 0,            0, 0, 0,     3, 4, 0, 0};
        tbl[9]  = '{1, 1, 7, 32'h11,       0, 0, 0,     7, 0, 0, 0};
        tbl[10] = '{0, 1, 1, 32'h55,       1, 2, 32'h66, 7, 0, 1, 0};
        tbl[11] = '{0, 1, 9, 32'h77,       1, 2, 32'h66, 7, 9, 1, 0};
        tbl[12] = '{1, 1, 7, 32'h22,       0, 0, 0,     7, 0, 1, 1};
        tbl[13] = '{1, 0, 0, 0,            0, 0, 0,     7, 7, 1, 1};
        tbl[14] = '{1, 1, 0, 32'h99,       0, 0, 0,     0, 7, 0, 0};
        tbl[15] = '{1, 0, 0, 0,            0, 0, 0,     0, 7, 0, 0};

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i])
            step(0, tbl[i].en, tbl[i].av, tbl[i].aa, tbl[i].ad,
                 tbl[i].mv, tbl[i].ma, tbl[i].md, tbl[i].q1, tbl[i].q2,
                 tbl[i].exp_count, tbl[i].exp_write);

        // Reset with an entry pending and a new request in flight.
        step(0, 1, 1, 12, 32'h33, 0, 0, 0, 12, 13, 0, 0);
        step(0, 0, 1, 13, 32'h44, 1, 14, 32'h45, 12, 13, 1, 0);
        step(1, 1, 1, 13, 32'h44, 0, 0, 0, 12, 13, -1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 12, 13, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 12, 13, 0, 0);

        // Random traffic against the scoreboard.
        for (int n = 0; n < 60; n++)
            step(0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), -1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
